// File: rtl/stream_pkg.sv
// Shared stream types for valid/ready register slices.
package stream_pkg;

  localparam int SLICE_DEPTH = 2;
  localparam int COUNT_W     = $clog2(SLICE_DEPTH + 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } slice_state_t;

  // Number of beats held by a slice in the given state.
  function automatic logic [COUNT_W-1:0] state_count(input slice_state_t s);
    logic [COUNT_W-1:0] c;
    case (s)
      BUSY:    c = COUNT_W'(1);
      FULL:    c = COUNT_W'(2);
      default: c = COUNT_W'(0);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ready_slice.sv
// Valid/ready register slice: main register plus skid register, so that
// valid, data and ready are all registered without losing throughput.
module ready_slice
  import stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             o_ready,
  output logic [1:0]       count
);

  slice_state_t     state_p1;
  slice_state_t     state_d;
  logic [WIDTH-1:0] main_p1;
  logic [WIDTH-1:0] skid_p1;
  logic             ready_p1;
  logic             vld_p1;
  logic [1:0]       count_p1;

  logic             accept;
  logic             consume;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid_in;
  logic             ready_d;
  logic             vld_d;
  logic [1:0]       count_d;

  assign accept  = i_valid & ready_p1;
  assign consume = vld_p1 & o_ready;

  // Next state and register load selects; flush overrides every transfer.
  always_comb begin
    state_d        = state_p1;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_p1)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_d      = BUSY;
          end
        end
        BUSY: begin
          if (accept && consume) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid_in = 1'b1;
            state_d      = FULL;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // i_ready is low here, so no upstream beat can arrive.
          if (consume) begin
            load_main_skid = 1'b1;
            state_d        = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Registered handshake outputs derived from the upcoming state.
  always_comb begin
    ready_d = (state_d != FULL);
    vld_d   = (state_d != EMPTY);
    count_d = state_count(state_d);
  end

  // ---- stage p1: state, handshake flags and both data registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1 <= EMPTY;
      ready_p1 <= 1'b0;
      vld_p1   <= 1'b0;
      count_p1 <= 2'd0;
      main_p1  <= '0;
      skid_p1  <= '0;
    end else begin
      state_p1 <= state_d;
      ready_p1 <= ready_d;
      vld_p1   <= vld_d;
      count_p1 <= count_d;
      if (load_main_in) begin
        main_p1 <= i_data;
      end else if (load_main_skid) begin
        main_p1 <= skid_p1;
      end
      if (load_skid_in) begin
        skid_p1 <= i_data;
      end
    end
  end

  assign i_ready = ready_p1;
  assign o_valid = vld_p1;
  assign o_data  = main_p1;
  assign count   = count_p1;

endmodule

// File: tb/tb_ready_slice.sv
// Self-checking bench for ready_slice: vector table, hand sequences and a
// randomized run against a queue-based model of a two-beat FIFO.
module tb_ready_slice;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             i_valid;
  logic [WIDTH-1:0] i_data;
  logic             i_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic             o_ready;
  logic [1:0]       count;

  ready_slice #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_ready (o_ready),
    .count   (count)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_acc   = 0;

  // Model: beats held, in order; ready is low during reset and whenever 2 are held.
  logic [WIDTH-1:0] mq[$];
  bit               m_rdy = 1'b0;

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
    logic             r;
    logic             f;
    logic             exp_ov;
    logic [WIDTH-1:0] exp_od;
    logic             exp_ir;
    logic [1:0]       exp_cnt;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_check(input string tag);
    chk({tag, " count"}, int'(count), mq.size());
    chk({tag, " o_valid"}, int'(o_valid), int'(mq.size() != 0));
    chk({tag, " i_ready"}, int'(i_ready), int'(m_rdy));
    if (mq.size() != 0) chk({tag, " o_data"}, int'(o_data), int'(mq[0]));
  endtask

  // One clock edge: apply the transfer rules to the model, sample #1 later.
  task automatic cycle();
    bit acc;
    bit con;
    acc = i_valid && m_rdy;
    con = (mq.size() != 0) && o_ready;
    @(posedge clk);
    #1;
    if (flush) begin
      mq.delete();
    end else begin
      if (con) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(i_data);
        n_acc++;
      end
    end
    m_rdy = (mq.size() < 2);
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
    i_valid = v;
    i_data  = d;
    o_ready = r;
    flush   = f;
  endtask

  initial begin
    int cyc;
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #2;
    chk("reset o_valid", int'(o_valid), 0);
    chk("reset i_ready", int'(i_ready), 0);
    chk("reset count",   int'(count),   0);
    chk("reset o_data",  int'(o_data),  0);
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b0;
    cycle();
    chk("i_ready after release", int'(i_ready), 1);
    model_check("post-reset");

    // Vector table: inputs for one edge, expected outputs after it.
    vecs[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 2'd1};
    vecs[1]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 2'd2};
    vecs[2]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 2'd2};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 2'd1};
    vecs[4]  = '{1'b1, 8'hB1, 1'b1, 1'b0, 1'b1, 8'hB1, 1'b1, 2'd1};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hB1, 1'b1, 2'd0};
    vecs[6]  = '{1'b1, 8'hC1, 1'b1, 1'b0, 1'b1, 8'hC1, 1'b1, 2'd1};
    vecs[7]  = '{1'b1, 8'hC2, 1'b0, 1'b0, 1'b1, 8'hC1, 1'b0, 2'd2};
    vecs[8]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 8'hC1, 1'b1, 2'd0};
    vecs[9]  = '{1'b1, 8'hD1, 1'b0, 1'b0, 1'b1, 8'hD1, 1'b1, 2'd1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hD1, 1'b1, 2'd1};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hD1, 1'b1, 2'd0};
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].f);
      cycle();
      chk($sformatf("vec%0d o_valid", i), int'(o_valid), int'(vecs[i].exp_ov));
      chk($sformatf("vec%0d i_ready", i), int'(i_ready), int'(vecs[i].exp_ir));
      chk($sformatf("vec%0d count", i),   int'(count),   int'(vecs[i].exp_cnt));
      if (vecs[i].exp_ov) chk($sformatf("vec%0d o_data", i), int'(o_data), int'(vecs[i].exp_od));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Streaming 0x01..0x10 back-to-back with o_ready high.
    for (int k = 1; k <= 16; k++) begin
      drive(1'b1, 8'(k), 1'b1, 1'b0);
      cycle();
      chk($sformatf("stream%0d o_data", k), int'(o_data), k);
      chk($sformatf("stream%0d i_ready", k), int'(i_ready), 1);
      model_check("stream");
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    cycle();
    model_check("stream drain");

    // Flush with two beats held and 0xFF presented in the flush cycle.
    drive(1'b1, 8'h31, 1'b0, 1'b0); cycle();
    drive(1'b1, 8'h32, 1'b0, 1'b0); cycle();
    chk("pre-flush count", int'(count), 2);
    drive(1'b1, 8'hFF, 1'b0, 1'b1); cycle();
    chk("flush count",   int'(count),   0);
    chk("flush o_valid", int'(o_valid), 0);
    chk("flush i_ready", int'(i_ready), 1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("post-flush o_valid", int'(o_valid), 0);
    end

    // Sustained accept-and-consume while BUSY.
    drive(1'b1, 8'h40, 1'b0, 1'b0); cycle();
    for (int k = 0; k < 100; k++) begin
      drive(1'b1, 8'(8'h41 + k), 1'b1, 1'b0);
      cycle();
      chk("busy count", int'(count), 1);
      chk("busy i_ready", int'(i_ready), 1);
      model_check("busy");
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0); cycle();
    model_check("busy drain");

    // Randomized traffic at 50% valid / 50% ready.
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      cycle();
      model_check("rand");
      cyc++;
    end
    chk("random beats accepted within budget", int'(n_acc >= 10000), 1);

    // Asynchronous reset mid-stream with two beats held.
    drive(1'b0, 8'h00, 1'b1, 1'b0); cycle(); cycle();
    drive(1'b1, 8'h51, 1'b0, 1'b0); cycle();
    drive(1'b1, 8'h52, 1'b0, 1'b0); cycle();
    chk("pre-reset count", int'(count), 2);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #2 reset = 1'b1;
    mq.delete();
    m_rdy = 1'b0;
    #1;
    chk("async reset o_valid", int'(o_valid), 0);
    chk("async reset i_ready", int'(i_ready), 0);
    chk("async reset count",   int'(count),   0);
    @(posedge clk);
    #3 reset = 1'b0;
    cycle();
    chk("i_ready one edge after release", int'(i_ready), 1);
    model_check("after reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
